// File: rtl/moving_avg_filter.sv
// moving_avg_filter
//   Running-sum moving-average filter over a window of DEPTH = 2**LOG2_DEPTH
//   unsigned samples. Each accepted sample updates the sum incrementally
//   (add newest, subtract the sample it evicts) and the registered average
//   appears one cycle later with a single-cycle out_valid pulse.
//
//   Optional build macro: MAVG_ROUND_EN
//     undefined : out_data = sum >> LOG2_DEPTH (truncate)
//     defined   : out_data = (sum + DEPTH/2) >> LOG2_DEPTH (round half up)
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   clear     in   synchronous window flush (overrides in_valid)
//   in_valid  in   in_data carries a sample this cycle
//   in_data   in   DATA_W-bit unsigned sample
//   out_valid out  one-cycle pulse, out_data is new
//   out_data  out  registered window average, held between pulses
//   primed    out  DEPTH samples accepted since last reset/clear

module moving_avg_filter #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned LOG2_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              primed
);

  localparam int unsigned Depth = 1 << LOG2_DEPTH;
  localparam int unsigned SumW  = DATA_W + LOG2_DEPTH;
  localparam int unsigned CntW  = LOG2_DEPTH + 1;

  // Sample buffer: never reset; stale entries are masked until primed.
  logic [DATA_W-1:0] mem_q [Depth];

  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [SumW-1:0]       sum_q, sum_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;

  logic [SumW-1:0]       old_ext;
  logic [SumW-1:0]       new_sum;
  logic [SumW-1:0]       avg_src;
  logic                  accept;

  assign primed    = (count_q == CntW'(Depth));
  assign accept    = in_valid & ~clear;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    // Before the window is full the evicted slot holds garbage, so treat it as zero.
    old_ext = primed ? SumW'(mem_q[wr_ptr_q]) : '0;
    // Intermediate wrap is harmless: the true result always fits in SumW bits.
    new_sum = sum_q + SumW'(in_data) - old_ext;
`ifdef MAVG_ROUND_EN
    // Max sum plus DEPTH/2 stays below 2**SumW, so no extra bit is needed.
    avg_src = new_sum + (SumW'(1) << (LOG2_DEPTH - 1));
`else
    avg_src = new_sum;
`endif
  end

  always_comb begin
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    if (clear) begin
      sum_d    = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (in_valid) begin
      sum_d       = new_sum;
      wr_ptr_d    = wr_ptr_q + LOG2_DEPTH'(1);
      count_d     = primed ? count_q : count_q + CntW'(1);
      out_valid_d = 1'b1;
      out_data_d  = avg_src[SumW-1:LOG2_DEPTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_moving_avg_filter.sv
// Self-checking bench for moving_avg_filter (DATA_W=8, LOG2_DEPTH=2).
// Reference model: a queue of the last DEPTH accepted samples, averaged
// with plain integer arithmetic (zero-filled before the window is full).

module tb_moving_avg_filter;

  localparam int DataW = 8;
  localparam int Log2D = 2;
  localparam int Depth = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic [DataW-1:0] in_data = '0;
  logic             out_valid;
  logic [DataW-1:0] out_data;
  logic             primed;

  moving_avg_filter #(
    .DATA_W    (DataW),
    .LOG2_DEPTH(Log2D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .primed   (primed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  int hist[$];
  int exp_data = 0;
  bit exp_valid = 1'b0;
  bit exp_primed = 1'b0;

  function automatic int window_avg();
    int s = 0;
    foreach (hist[i]) s += hist[i];
`ifdef MAVG_ROUND_EN
    return (s + Depth / 2) / Depth;
`else
    return s / Depth;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    exp_data   = 0;
    exp_valid  = 1'b0;
    exp_primed = 1'b0;
  endtask

  // One clock: drive inputs, step the model, compare at posedge+1.
  task automatic cycle(input bit v, input int d, input bit c, input int lit, input string tag);
    logic [31:0] dv;
    dv       = d;
    in_valid = v;
    in_data  = dv[DataW-1:0];
    clear    = c;
    @(posedge clk);
    #1;
    if (c) begin
      hist.delete();
      exp_valid  = 1'b0;
      exp_primed = 1'b0;
    end else if (v) begin
      hist.push_back(d);
      if (hist.size() > Depth) void'(hist.pop_front());
      exp_data   = window_avg();
      exp_valid  = 1'b1;
      exp_primed = (hist.size() == Depth);
    end else begin
      exp_valid = 1'b0;
    end
    if (out_valid === 1'b1) pulses++;
    check({tag, ".valid"}, out_valid, exp_valid);
    check({tag, ".data"}, out_data, exp_data);
    check({tag, ".primed"}, primed, exp_primed);
    if (lit >= 0) check({tag, ".lit"}, out_data, lit);
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

`ifdef MAVG_ROUND_EN
  localparam int Sat1 = 64;
  localparam int Sat2 = 128;
  localparam int Rnd  = 1;
`else
  localparam int Sat1 = 63;
  localparam int Sat2 = 127;
  localparam int Rnd  = 0;
`endif

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b1;
    #2;
    check("rst.valid", out_valid, 0);
    check("rst.data", out_data, 0);
    check("rst.primed", primed, 0);
    #9 rst = 1'b0;
    model_reset();

    // Fill and wrap.
    cycle(1, 4, 0, 1, "fill0");
    cycle(1, 8, 0, 3, "fill1");
    cycle(1, 12, 0, 6, "fill2");
    cycle(1, 16, 0, 10, "fill3");
    check("fill3.primed_lit", primed, 1);
    cycle(1, 20, 0, 14, "wrap");
    cycle(0, 0, 0, 14, "idle_hold");

    // Full-scale samples, no overflow.
    cycle(0, 0, 1, -1, "clr_a");
    check("clr_a.primed_lit", primed, 0);
    cycle(1, 255, 0, Sat1, "max0");
    cycle(1, 255, 0, Sat2, "max1");
    cycle(1, 255, 0, 191, "max2");
    cycle(1, 255, 0, 255, "max3");
    cycle(1, 0, 0, 191, "max_evict");

    // Gapped input: exactly two pulses, output held in between.
    cycle(0, 0, 1, -1, "clr_b");
    pulses = 0;
    cycle(1, 4, 0, 1, "gap_s0");
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, "gap_idle0");
    cycle(1, 8, 0, 3, "gap_s1");
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 3, "gap_idle1");
    check("gap.pulses", pulses, 2);

    // Clear overrides a simultaneous sample.
    cycle(1, 10, 0, -1, "pc0");
    cycle(1, 20, 0, -1, "pc1");
    cycle(1, 30, 0, -1, "pc2");
    cycle(1, 40, 0, -1, "pc3");
    check("pc3.primed_lit", primed, 1);
    cycle(1, 100, 1, -1, "clr_in");
    check("clr_in.valid_lit", out_valid, 0);
    check("clr_in.primed_lit", primed, 0);
    cycle(1, 8, 0, 2, "post_clr");

    // Reset between edges with a sample in flight.
    cycle(1, 4, 0, -1, "pr0");
    cycle(1, 8, 0, -1, "pr1");
    in_valid = 1'b1;
    in_data  = 8'd50;
    #2 rst = 1'b1;
    #1;
    check("mid_rst.valid", out_valid, 0);
    check("mid_rst.data", out_data, 0);
    check("mid_rst.primed", primed, 0);
    model_reset();
    #1 rst = 1'b0;
    in_valid = 1'b0;
    cycle(1, 4, 0, 1, "after_rst0");
    cycle(1, 4, 0, 2, "after_rst1");

    // Rounding vs truncation.
    cycle(0, 0, 1, -1, "clr_c");
    cycle(1, 2, 0, Rnd, "rnd0");
    cycle(1, 0, 0, Rnd, "rnd1");
    cycle(0, 0, 1, -1, "clr_d");
    for (int i = 0; i < 3; i++) cycle(1, 255, 0, -1, "rmax");
    cycle(1, 255, 0, 255, "rmax3");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(9, 0) < 7, int'($urandom_range(255, 0)),
            $urandom_range(39, 0) == 0, -1, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
